uart_tx: RTL and testbench

UART transmitter and the transmit-side counterpart of the existing receive path (d_ff_chain synchronizer plus receiver). It accepts a parallel word over a valid/ready handshake and serializes it as start bit, data LSB-first, optional parity and stop bit(s). Each bit lasts a fixed number of clk cycles. The output `tx` is registered and glitch-free so it can drive the pad directly.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_gen.sv | 35 +++
 rtl/uart_tx.sv | 127 ++++++++++++
 tb/tb_uart_tx.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame-length helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int unsigned START_BITS = 1;

  // Number of bit times in one frame.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity_en,
                                             input int unsigned stop_bits);
    return START_BITS + data_bits + parity_en + stop_bits;
  endfunction

  // Number of clk cycles in one frame.
  function automatic int unsigned frame_cycles(input int unsigned clk_div,
                                               input int unsigned data_bits,
                                               input int unsigned parity_en,
                                               input int unsigned stop_bits);
    return clk_div * frame_bits(data_bits, parity_en, stop_bits);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Restartable modulo-CLK_DIV counter; bit_end is high while the count sits at CLK_DIV-1.
module uart_baud_gen #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic RSTn,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Next count: hold at zero on restart, wrap at the last cycle of a bit.
  always_comb begin
    cnt_nxt = cnt + CW'(1);
    if (restart || (cnt == CW'(CLK_DIV - 1))) begin
      cnt_nxt = '0;
    end
  end

  // Count register; bit_end is registered from the next count so it aligns with cnt.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      bit_end <= (cnt_nxt == CW'(CLK_DIV - 1));
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, start + LSB-first data + optional parity + stop bits out.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 RSTn,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int unsigned BCW = $clog2(DATA_BITS + 1);

  uart_tx_state_t       state, state_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [BCW-1:0]       bit_cnt, bit_cnt_nxt;
  logic                 stop_cnt, stop_cnt_nxt;
  logic                 par, par_nxt;
  logic                 tx_nxt;
  logic                 ready_nxt;
  logic                 baud_restart;
  logic                 bit_end;

  // Divider is held at zero while idle so every frame starts on a clean bit boundary.
  assign baud_restart = (state == IDLE);

  uart_baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk    (clk),
    .RSTn   (RSTn),
    .restart(baud_restart),
    .bit_end(bit_end)
  );

  // State, shift register, counters and parity register.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      par      <= par_nxt;
      tx       <= tx_nxt;
      tx_ready <= ready_nxt;
      tx_busy  <= ~ready_nxt;
    end
  end

  // Next-state logic; line level is decoded from the next state so tx is a clean flop output.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    par_nxt      = par;
    tx_nxt       = 1'b1;
    ready_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_nxt    = START;
          shreg_nxt    = tx_data;
          par_nxt      = (^tx_data) ^ 1'(PARITY_ODD);
          bit_cnt_nxt  = '0;
          stop_cnt_nxt = 1'b0;
        end
      end
      START: begin
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shreg_nxt = shreg >> 1;
          if (bit_cnt == BCW'(DATA_BITS - 1)) begin
            bit_cnt_nxt = '0;
            state_nxt   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + BCW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state_nxt    = IDLE;
            stop_cnt_nxt = 1'b0;
          end else begin
            stop_cnt_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    unique case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      PARITY:  tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase

    ready_nxt = (state_nxt == IDLE);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations driven in parallel against a frame-level model.
module tb_uart_tx;

  localparam int DIV = 4;
  localparam int NI  = 4;

  logic          clk;
  logic          rst_n;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic [NI-1:0] tx;
  logic [NI-1:0] tx_ready;
  logic [NI-1:0] tx_busy;

  int errors;
  int checks;

  // inst0: no parity, 1 stop; inst1: even parity; inst2: odd parity; inst3: 2 stop bits
  uart_tx #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .RSTn(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready[0]), .tx(tx[0]), .tx_busy(tx_busy[0]));
  uart_tx #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .RSTn(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready[1]), .tx(tx[1]), .tx_busy(tx_busy[1]));
  uart_tx #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .RSTn(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready[2]), .tx(tx[2]), .tx_busy(tx_busy[2]));
  uart_tx #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .RSTn(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready[3]), .tx(tx[3]), .tx_busy(tx_busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pe_of(input int k);
    return (k == 1 || k == 2) ? 1 : 0;
  endfunction

  function automatic int po_of(input int k);
    return (k == 2) ? 1 : 0;
  endfunction

  function automatic int sb_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int flen(input int k);
    return (1 + 8 + pe_of(k) + sb_of(k)) * DIV;
  endfunction

  // Expected line level at cycle pos (1-based) of a frame carrying d.
  function automatic logic level(input int k, input logic [7:0] d, input int pos);
    int b;
    b = (pos - 1) / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pe_of(k) != 0 && b == 9) return 1'(($countones(d) + po_of(k)) % 2);
    return 1'b1;
  endfunction

  // Frame-level model: a word is taken whenever an instance is idle and valid is high.
  logic       m_busy [NI];
  logic [7:0] m_data [NI];
  int         m_pos  [NI];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_busy[k] <= 1'b0;
        m_data[k] <= 8'h00;
        m_pos[k]  <= 0;
      end else if (!m_busy[k]) begin
        if (tx_valid) begin
          m_busy[k] <= 1'b1;
          m_data[k] <= tx_data;
          m_pos[k]  <= 1;
        end
      end else if (m_pos[k] == flen(k)) begin
        m_busy[k] <= 1'b0;
      end else begin
        m_pos[k] <= m_pos[k] + 1;
      end
    end
  end

  function automatic logic exp_tx(input int k);
    if (!m_busy[k]) return 1'b1;
    return level(k, m_data[k], m_pos[k]);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (tx[k] !== 1'b1 || tx_ready[k] !== 1'b1 || tx_busy[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset inst%0d cyc%0d: tx=%b ready=%b busy=%b expected 1 1 0",
                   k, i, tx[k], tx_ready[k], tx_busy[k]);
        end
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (tx[k] !== 1'b1 || tx_ready[k] !== 1'b1) begin
          errors++;
          $display("FAIL idle inst%0d cyc%0d: tx=%b ready=%b expected 1 1", k, i, tx[k], tx_ready[k]);
        end
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] words [4];
    int low_cnt;
    words[0] = 8'h55;
    for (int w = 1; w < 4; w++) words[w] = 8'($urandom);
    for (int w = 0; w < 4; w++) begin
      tx_data = words[w]; tx_valid = 1'b1;
      low_cnt = 0;
      for (int i = 1; i <= 46; i++) begin
        @(negedge clk);
        tx_valid = 1'b0;
        if (tx_ready[0] === 1'b0) low_cnt++;
        for (int k = 0; k < NI; k++) begin
          checks++;
          if (tx[k] !== exp_tx(k) || tx_ready[k] !== !m_busy[k] || tx_busy[k] !== m_busy[k]) begin
            errors++;
            $display("FAIL basic w=%h inst%0d cyc%0d: tx=%b ready=%b busy=%b expected %b %b %b",
                     words[w], k, i, tx[k], tx_ready[k], tx_busy[k], exp_tx(k), !m_busy[k], m_busy[k]);
          end
        end
        if (i == 41) begin
          checks++;
          if (tx_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready41 w=%h: ready=%b expected 1", words[w], tx_ready[0]);
          end
        end
      end
      checks++;
      if (low_cnt != 40) begin
        errors++;
        $display("FAIL basic_ready_low w=%h: low cycles=%0d expected 40", words[w], low_cnt);
      end
    end
  endtask

  task automatic test_parity();
    int busy1;
    tx_data = 8'hA3; tx_valid = 1'b1;
    busy1 = 0;
    for (int i = 1; i <= 46; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      if (tx_busy[1] === 1'b1) busy1++;
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (tx[k] !== exp_tx(k) || tx_ready[k] !== !m_busy[k]) begin
          errors++;
          $display("FAIL parity inst%0d cyc%0d: tx=%b ready=%b expected %b %b",
                   k, i, tx[k], tx_ready[k], exp_tx(k), !m_busy[k]);
        end
      end
      if (i == 38) begin
        checks++;
        if (tx[1] !== 1'b0 || tx[2] !== 1'b1) begin
          errors++;
          $display("FAIL parity_bit: even=%b odd=%b expected 0 1", tx[1], tx[2]);
        end
      end
    end
    checks++;
    if (busy1 != 44) begin
      errors++;
      $display("FAIL parity_len: busy cycles=%0d expected 44", busy1);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    tx_data = 8'h0F; tx_valid = 1'b1;
    gap = 0;
    for (int i = 1; i <= 84; i++) begin
      @(negedge clk);
      tx_data = 8'hF0;
      if (i == 42) tx_valid = 1'b0;
      if (i <= 81 && tx_ready[0] === 1'b1) gap++;
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (tx[k] !== exp_tx(k) || tx_ready[k] !== !m_busy[k]) begin
          errors++;
          $display("FAIL b2b inst%0d cyc%0d: tx=%b ready=%b expected %b %b",
                   k, i, tx[k], tx_ready[k], exp_tx(k), !m_busy[k]);
        end
      end
    end
    checks++;
    if (gap != 1) begin
      errors++;
      $display("FAIL b2b_gap: idle cycles between frames=%0d expected 1", gap);
    end
  endtask

  task automatic test_busy_hold();
    int ones;
    tx_data = 8'h00; tx_valid = 1'b1;
    ones = 0;
    for (int i = 1; i <= 46; i++) begin
      @(negedge clk);
      if (i >= 5 && i <= 36 && tx[0] === 1'b1) ones++;
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (tx[k] !== exp_tx(k) || tx_ready[k] !== !m_busy[k]) begin
          errors++;
          $display("FAIL busy_hold inst%0d cyc%0d: tx=%b ready=%b expected %b %b",
                   k, i, tx[k], tx_ready[k], exp_tx(k), !m_busy[k]);
        end
      end
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      if (i == 10) begin
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
      end
    end
    checks++;
    if (ones != 0) begin
      errors++;
      $display("FAIL busy_hold_data: high data cycles=%0d expected 0", ones);
    end
  endtask

  task automatic test_mid_reset();
    int stop_hi;
    tx_data = 8'($urandom) & 8'hFB; tx_valid = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (tx[k] !== exp_tx(k) || tx_ready[k] !== !m_busy[k]) begin
          errors++;
          $display("FAIL pre_reset inst%0d cyc%0d: tx=%b ready=%b expected %b %b",
                   k, i, tx[k], tx_ready[k], exp_tx(k), !m_busy[k]);
        end
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (tx[k] !== 1'b1 || tx_ready[k] !== 1'b1 || tx_busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset inst%0d: tx=%b ready=%b busy=%b expected 1 1 0",
                 k, tx[k], tx_ready[k], tx_busy[k]);
      end
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tx_data = 8'h81; tx_valid = 1'b1;
    stop_hi = 0;
    for (int i = 1; i <= 46; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      if (i >= 37 && i <= 44 && tx[3] === 1'b1 && tx_busy[3] === 1'b1) stop_hi++;
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (tx[k] !== exp_tx(k) || tx_ready[k] !== !m_busy[k]) begin
          errors++;
          $display("FAIL post_reset inst%0d cyc%0d: tx=%b ready=%b expected %b %b",
                   k, i, tx[k], tx_ready[k], exp_tx(k), !m_busy[k]);
        end
      end
    end
    checks++;
    if (stop_hi != 8) begin
      errors++;
      $display("FAIL stop2_len: stop high cycles=%0d expected 8", stop_hi);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_busy_hold();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
